// File: rtl/mem_stage.sv
// Pipeline MEM stage: registers the EX->MEM bus under stall control, extracts and
// extends load data from the synchronous SRAM, and drives the WB and forwarding buses.
module mem_stage #(
  parameter int unsigned EX_TO_MEM_WD = 76,
  parameter int unsigned MEM_TO_WB_WD = 70,
  parameter int unsigned MEM_TO_RF_WD = 38,
  parameter int unsigned STALL_WD     = 6,
  parameter int unsigned LOAD_WD      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [LOAD_WD-1:0]      ex_load_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
  output logic                    mem_is_load
);

  localparam int unsigned DATA_WD = 32;

  logic [EX_TO_MEM_WD-1:0] bus_r;
  logic [LOAD_WD-1:0]      load_r;
  logic                    fresh;
  logic [DATA_WD-1:0]      hold;

  logic               stop_mem;
  logic               stop_wb;
  logic [31:0]        pc;
  logic               sel_rf_res;
  logic               rf_we;
  logic [4:0]         rf_waddr;
  logic [DATA_WD-1:0] ex_result;
  logic [1:0]         addr;

  logic [DATA_WD-1:0] rd;
  logic [7:0]         byte_val;
  logic [15:0]        half_val;
  logic [DATA_WD-1:0] load_data;
  logic [DATA_WD-1:0] rf_wdata;

  assign stop_mem = stall[3];
  assign stop_wb  = stall[4];

  // Stall bits belonging to other stages, and the store mask, are not consumed here.
  logic unused_bits;
  assign unused_bits = ^{stall[STALL_WD-1:5], stall[2:0], bus_r[42:39]};

  // fresh marks the one cycle in which the SRAM port carries this load's data;
  // hold keeps that data once the port moves on during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_r  <= '0;
      load_r <= '0;
      fresh  <= 1'b0;
      hold   <= '0;
    end else begin
      if (fresh) hold <= data_sram_rdata;
      if (stop_mem && !stop_wb) begin
        bus_r  <= '0;
        load_r <= '0;
        fresh  <= 1'b0;
      end else if (!stop_mem) begin
        bus_r  <= ex_to_mem_bus;
        load_r <= ex_load_bus;
        fresh  <= ex_to_mem_bus[43];
      end else begin
        fresh  <= 1'b0;
      end
    end
  end

  assign pc         = bus_r[75:44];
  assign sel_rf_res = bus_r[38];
  assign rf_we      = bus_r[37];
  assign rf_waddr   = bus_r[36:32];
  assign ex_result  = bus_r[31:0];
  assign addr       = ex_result[1:0];

  // Little-endian lane select and sign/zero extension of the load result.
  always_comb begin
    rd        = fresh ? data_sram_rdata : hold;
    byte_val  = 8'h00;
    half_val  = addr[1] ? rd[31:16] : rd[15:0];
    load_data = rd;
    case (addr)
      2'd0:    byte_val = rd[7:0];
      2'd1:    byte_val = rd[15:8];
      2'd2:    byte_val = rd[23:16];
      default: byte_val = rd[31:24];
    endcase
    if (load_r[4])      load_data = {{24{byte_val[7]}}, byte_val};
    else if (load_r[3]) load_data = {24'h0, byte_val};
    else if (load_r[2]) load_data = {{16{half_val[15]}}, half_val};
    else if (load_r[1]) load_data = {16'h0, half_val};
    rf_wdata = sel_rf_res ? load_data : ex_result;
  end

  assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
  assign mem_to_rf_bus = mem_to_wb_bus[MEM_TO_RF_WD-1:0];
  assign mem_is_load   = |load_r;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// compared against a field-level reference model.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [75:0] ex_to_mem_bus;
  logic [4:0]  ex_load_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_rf_bus;
  logic        mem_is_load;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [4:0] LB = 5'b10000, LBU = 5'b01000, LH = 5'b00100,
                         LHU = 5'b00010, LW = 5'b00001, NOLD = 5'b00000;

  mem_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_to_mem_bus(ex_to_mem_bus),
    .ex_load_bus(ex_load_bus), .data_sram_rdata(data_sram_rdata),
    .mem_to_wb_bus(mem_to_wb_bus), .mem_to_rf_bus(mem_to_rf_bus),
    .mem_is_load(mem_is_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instruction sitting in MEM, as plain fields.
  logic [31:0] m_pc, m_res, m_hold;
  logic        m_en, m_sel, m_we, m_fresh;
  logic [4:0]  m_waddr, m_load;

  function automatic logic [75:0] mk(logic [31:0] pc, logic en, logic sel, logic we,
                                     logic [4:0] waddr, logic [31:0] res);
    return {pc, en, 4'h0, sel, we, waddr, res};
  endfunction

  task automatic check(string tag, logic [69:0] got, logic [69:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance the model with the inputs present before the edge, then take the edge.
  task automatic tick();
    if (rst) begin
      {m_pc, m_en, m_sel, m_we, m_waddr, m_res, m_load, m_fresh, m_hold} = '0;
    end else begin
      if (m_fresh) m_hold = data_sram_rdata;
      if (stall[3] && !stall[4]) begin
        {m_pc, m_en, m_sel, m_we, m_waddr, m_res, m_load, m_fresh} = '0;
      end else if (!stall[3]) begin
        m_pc    = ex_to_mem_bus[75:44];
        m_en    = ex_to_mem_bus[43];
        m_sel   = ex_to_mem_bus[38];
        m_we    = ex_to_mem_bus[37];
        m_waddr = ex_to_mem_bus[36:32];
        m_res   = ex_to_mem_bus[31:0];
        m_load  = ex_load_bus;
        m_fresh = m_en;
      end else begin
        m_fresh = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_wdata();
    logic [31:0] rd, lane, half, ld;
    int a;
    rd   = m_fresh ? data_sram_rdata : m_hold;
    a    = int'(m_res[1:0]);
    lane = (rd >> (8 * a)) % 256;
    half = (m_res[1] ? (rd >> 16) : rd) % 65536;
    case (m_load)
      LB:      ld = (lane >= 128) ? lane - 32'd256 : lane;
      LBU:     ld = lane;
      LH:      ld = (half >= 32768) ? half - 32'd65536 : half;
      LHU:     ld = half;
      default: ld = rd;
    endcase
    return m_sel ? ld : m_res;
  endfunction

  task automatic check_model(string tag);
    logic [69:0] exp;
    exp = {m_pc, m_we, m_waddr, model_wdata()};
    check({tag, ".wb"}, mem_to_wb_bus, exp);
    check({tag, ".rf"}, 70'(mem_to_rf_bus), 70'(exp[37:0]));
    check({tag, ".ld"}, 70'(mem_is_load), 70'(m_load != 5'd0));
  endtask

  logic [31:0] ext_addr [5];
  logic [4:0]  ext_load [5];
  logic [31:0] ext_exp  [5];

  initial begin
    rst = 1'b1; stall = '0; ex_to_mem_bus = '0; ex_load_bus = '0; data_sram_rdata = 32'hA5A5A5A5;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("reset.wb", mem_to_wb_bus, 70'h0);
    check("reset.rf", 70'(mem_to_rf_bus), 70'h0);
    check("reset.ld", 70'(mem_is_load), 70'h0);

    // ALU pass-through
    ex_to_mem_bus = mk(32'hBFC00010, 1'b0, 1'b0, 1'b1, 5'd5, 32'h12345678);
    ex_load_bus = NOLD;
    tick(); #1;
    check("alu.wb", mem_to_wb_bus, {32'hBFC00010, 1'b1, 5'd5, 32'h12345678});
    check("alu.rf", 70'(mem_to_rf_bus), 70'({1'b1, 5'd5, 32'h12345678}));

    // Byte / half / word extraction from 0x80FF7F01
    ext_addr = '{32'h1003, 32'h1003, 32'h1002, 32'h1000, 32'h1001};
    ext_load = '{LB, LBU, LH, LHU, LW};
    ext_exp  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
    for (int i = 0; i < 5; i++) begin
      ex_to_mem_bus = mk(32'h400 + 32'(4 * i), 1'b1, 1'b1, 1'b1, 5'd9, ext_addr[i]);
      ex_load_bus = ext_load[i];
      tick();
      data_sram_rdata = 32'h80FF7F01;
      #1;
      check($sformatf("ext%0d", i), 70'(mem_to_wb_bus[31:0]), 70'(ext_exp[i]));
    end

    // Stall hold: data must survive the SRAM port changing
    ex_to_mem_bus = mk(32'h500, 1'b1, 1'b1, 1'b1, 5'd3, 32'h2000);
    ex_load_bus = LW;
    tick();
    data_sram_rdata = 32'hDEADBEEF;
    #1;
    check("hold.first", 70'(mem_to_wb_bus[31:0]), 70'h0DEADBEEF);
    stall = 6'b011000;
    for (int i = 0; i < 3; i++) begin
      tick();
      data_sram_rdata = 32'h0;
      #1;
      check($sformatf("hold.c%0d", i), 70'(mem_to_wb_bus[31:0]), 70'h0DEADBEEF);
      check($sformatf("hold.ld%0d", i), 70'(mem_is_load), 70'h1);
    end

    // Reset while the load is stalled
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid.wb", mem_to_wb_bus, 70'h0);
    check("rst_mid.ld", 70'(mem_is_load), 70'h0);
    stall = '0;
    ex_to_mem_bus = mk(32'h600, 1'b0, 1'b1, 1'b1, 5'd4, 32'h3);
    ex_load_bus = NOLD;
    tick();
    data_sram_rdata = 32'h55555555;
    #1;
    check("rst_mid.hold", 70'(mem_to_wb_bus[31:0]), 70'h0);

    // Bubble insertion behind a load
    ex_to_mem_bus = mk(32'h100, 1'b1, 1'b1, 1'b1, 5'd7, 32'h0);
    ex_load_bus = LW;
    tick();
    data_sram_rdata = 32'h13579BDF;
    stall = 6'b001000;
    tick(); #1;
    check("bubble.wb", mem_to_wb_bus, 70'h0);
    check("bubble.ld", 70'(mem_is_load), 70'h0);
    stall = '0;
    tick();
    data_sram_rdata = 32'h2468ACE0;
    #1;
    check("bubble.rel", mem_to_wb_bus, {32'h100, 1'b1, 5'd7, 32'h2468ACE0});

    // Back-to-back loads
    ex_to_mem_bus = mk(32'h700, 1'b1, 1'b1, 1'b1, 5'd1, 32'h3000);
    ex_load_bus = LW;
    tick();
    data_sram_rdata = 32'h11111111;
    ex_to_mem_bus = mk(32'h704, 1'b1, 1'b1, 1'b1, 5'd2, 32'h3001);
    ex_load_bus = LBU;
    #1;
    check("b2b.lw", 70'(mem_to_wb_bus[31:0]), 70'h11111111);
    tick();
    data_sram_rdata = 32'h0000AB00;
    #1;
    check("b2b.lbu", 70'(mem_to_wb_bus[31:0]), 70'h000000AB);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [4:0] ld;
      case ($urandom_range(0, 6))
        0: ld = LB;  1: ld = LBU; 2: ld = LH; 3: ld = LHU; 4: ld = LW;
        default: ld = NOLD;
      endcase
      rst   = ($urandom_range(0, 49) == 0);
      stall = 6'($urandom);
      ex_to_mem_bus = mk($urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                         5'($urandom), $urandom);
      ex_load_bus = ld;
      #1;
      tick();
      data_sram_rdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      #1;
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of the EX stage.
- Registers the EX→MEM bus and load-type bus under stall control.
- Extracts and extends load data from the synchronous data SRAM read port; holds that read data stable across MEM stalls.
- Produces the MEM→WB bus and the MEM→regfile forwarding bus.

Parameters:
EX_TO_MEM_WD, 76, width of ex_to_mem_bus
MEM_TO_WB_WD, 70, width of mem_to_wb_bus
MEM_TO_RF_WD, 38, width of mem_to_rf_bus
STALL_WD, 6, width of stall bus
LOAD_WD, 5, width of load-type bus

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
stall  input  STALL_WD  per-stage stall vector; 1 = Stop; bit3 = MEM input register, bit4 = WB input register
ex_to_mem_bus  input  EX_TO_MEM_WD  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
ex_load_bus  input  LOAD_WD  {inst_lb, inst_lbu, inst_lh, inst_lhu, inst_lw}, one-hot or zero
data_sram_rdata  input  32  SRAM read data, valid the cycle after EX issued the address
mem_to_wb_bus  output  MEM_TO_WB_WD  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}
mem_to_rf_bus  output  MEM_TO_RF_WD  {rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}, forwarding to ID
mem_is_load  output  1  OR of registered load bits, for load-use hazard detection

Behaviour:
- One clock `clk`; synchronous, active-high reset `rst`.
- Input register update on each clk edge, priority order:
  - rst: clear bus register, load register, fresh flag and hold register to 0.
  - else stall[3]=Stop and stall[4]=NoStop: load a bubble (all 0).
  - else stall[3]=NoStop: load ex_to_mem_bus and ex_load_bus.
  - else (both Stop): hold all registers.
- Fresh flag:
  - Set to 1 on an edge that loads a non-bubble bus whose data_ram_en=1.
  - Cleared to 0 on any other edge.
- Hold register:
  - Captures data_sram_rdata on every edge where fresh=1.
  - Otherwise keeps its value.
- Effective read data rd = fresh ? data_sram_rdata : hold.
  - The value is therefore stable for any number of MEM stall cycles after the first.
- Load extraction uses a = registered ex_result[1:0], little-endian byte lanes:
  - lb/lbu: byte rd[8a+7:8a]; lb sign-extends, lbu zero-extends.
  - lh/lhu: half rd[31:16] if a[1]=1, else rd[15:0]; lh sign-extends, lhu zero-extends; a[0] ignored.
  - lw: rd; a ignored.
  - Misaligned addresses raise no exception.
- rf_wdata = sel_rf_res ? load_data : ex_result.
  - sel_rf_res=1 with no load bit set gives rf_wdata = rd.
- Outputs are purely combinational from the registered state plus data_sram_rdata.
- A bubble gives every output field 0; rf_we=0 guarantees no write.
- mem_to_rf_bus always equals mem_to_wb_bus[37:0]. Forwarding of a load value is valid in MEM; ID must not rely on it for the immediately following instruction (mem_is_load drives the stall).
- Reset state: all outputs 0.
  - rd = data_sram_rdata only if fresh, so at reset load outputs are 0.
- Reset mid-stall: registers cleared on the next edge regardless of stall; the held load data is discarded.
- Latency:
  - Instruction appears on mem_to_wb_bus one cycle after EX presents it.
  - WB consumes it on the following edge when stall[4]=NoStop.

Test Plan:
- ALU pass-through: ex_to_mem_bus pc=0xBFC00010, rf_we=1, waddr=5, ex_result=0x1234_5678, sel_rf_res=0 -> next cycle mem_to_wb_bus = {0xBFC00010, 1, 5, 0x12345678}; mem_to_rf_bus matches low 38 bits.
- Byte/half extraction: rdata=0x80FF_7F01, loads at addr 0x...03, 0x...02, 0x...00 ->
  - lb@3 = 0xFFFFFF80
  - lbu@3 = 0x00000080
  - lh@2 = 0xFFFF80FF
  - lhu@0 = 0x00007F01
  - lw@1 = 0x80FF7F01
- Stall hold: lw enters MEM with rdata=0xDEADBEEF; stall[3]=stall[4]=Stop for 3 cycles while rdata changes to 0x0 -> rf_wdata stays 0xDEADBEEF each cycle; mem_is_load stays 1.
- Bubble insertion: stall[3]=Stop, stall[4]=NoStop for 1 cycle -> next cycle mem_to_wb_bus = 0, mem_is_load = 0; then stall released -> the EX instruction appears.
- Reset mid-operation: rst asserted for 1 cycle while lw is held under stall -> outputs 0 next cycle; hold register reads 0 on a later non-fresh load-less cycle.
- Back-to-back loads without stall: lw (rdata 0x11111111) then lbu@1 (rdata 0x0000AB00) -> consecutive cycles give rf_wdata 0x11111111 then 0x000000AB.
